// File: rtl/alarm_pkg.sv
// alarm_pkg
//   Shared definitions for the alarm beep controller: the FSM state
//   encoding, default cadence timing constants and a small helper used
//   to size the shared duration counter.
//   Ports: none (package).
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BEEP_ON,
        BEEP_OFF,
        GAP,
        SNOOZE
    } alarm_state_t;

    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_ON_TICKS     = 200;
    localparam int DEF_OFF_TICKS    = 100;
    localparam int DEF_BURSTS       = 3;
    localparam int DEF_GAP_TICKS    = 1000;
    localparam int DEF_RING_TICKS   = 60000;
    localparam int DEF_SNOOZE_TICKS = 300000;
    localparam int DEF_MAX_SNOOZE   = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_beep_ctrl_tick_gen.sv
// tick_gen
//   Tick prescaler for the alarm beep controller. Counts clk cycles and
//   emits a one-cycle tick when the count reaches TICK_DIV-1. A sync
//   clear restarts the count at 0 so every state begins on a tick boundary.
//   Ports:
//     clk   in  system clock
//     rstn  in  asynchronous active-low reset
//     clear in  synchronous restart of the prescaler
//     tick  out one-cycle pulse every TICK_DIV cycles
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_beep_ctrl.sv
// alarm_beep_ctrl
//   Turns the alarm-match event into the beep cadence for the sound
//   player: BURSTS beeps (ON/OFF), a GAP, repeat, until stop or until the
//   ring timer expires. Optional snooze, built when ALARM_SNOOZE_EN is
//   defined; without it the snooze input is ignored and snoozed is 0.
//   Ports:
//     clk       in  system clock
//     rstn      in  asynchronous active-low reset
//     alarm_hit in  alarm time matched
//     stop      in  silence the alarm (highest priority)
//     snooze    in  snooze request, rising-edge detected
//     aud_en    out 1 = play tone (BEEP_ON)
//     ringing   out in BEEP_ON / BEEP_OFF / GAP
//     snoozed   out in SNOOZE
//     timeout   out one-cycle pulse when the ring timer expires
module alarm_beep_ctrl
    import alarm_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int ON_TICKS     = DEF_ON_TICKS,
    parameter int OFF_TICKS    = DEF_OFF_TICKS,
    parameter int BURSTS       = DEF_BURSTS,
    parameter int GAP_TICKS    = DEF_GAP_TICKS,
    parameter int RING_TICKS   = DEF_RING_TICKS,
    parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS,
    parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
    input  logic clk,
    input  logic rstn,
    input  logic alarm_hit,
    input  logic stop,
    input  logic snooze,
    output logic aud_en,
    output logic ringing,
    output logic snoozed,
    output logic timeout
);

`ifdef ALARM_SNOOZE_EN
    localparam int DUR_MAX = max_int(max_int(ON_TICKS, OFF_TICKS),
                                     max_int(GAP_TICKS, SNOOZE_TICKS));
    localparam int SNZ_W   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
`else
    localparam int DUR_MAX = max_int(max_int(ON_TICKS, OFF_TICKS), GAP_TICKS);
`endif
    localparam int DUR_W   = $clog2(DUR_MAX + 1);
    localparam int BURST_W = $clog2(BURSTS + 1);
    localparam int RING_W  = $clog2(RING_TICKS + 1);

    alarm_state_t       state, state_next;
    logic               tick;
    logic               state_change;
    logic               ring_state;
    logic               ring_expire;
    logic               dur_done;
    logic               snooze_take;
    logic [DUR_W-1:0]   dur_cnt;
    logic [DUR_W-1:0]   dur_last;
    logic [BURST_W-1:0] burst_cnt;
    logic [RING_W-1:0]  ring_cnt;

    assign state_change = (state_next != state);

    // Restarting the prescaler on every state change keeps each state an
    // exact multiple of TICK_DIV cycles.
    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clear(state_change),
        .tick (tick)
    );

    assign ring_state  = (state == BEEP_ON) || (state == BEEP_OFF) || (state == GAP);
    assign ring_expire = ring_state && tick && (ring_cnt == RING_W'(RING_TICKS - 1));

`ifdef ALARM_SNOOZE_EN
    logic             snooze_d;
    logic [SNZ_W-1:0] snooze_cnt;

    assign snooze_take = ring_state && snooze && !snooze_d
                         && (snooze_cnt < SNZ_W'(MAX_SNOOZE));
    assign snoozed     = (state == SNOOZE);

    // Snooze count survives stop; only a fresh alarm from IDLE clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snooze_d   <= 1'b0;
            snooze_cnt <= '0;
        end else begin
            snooze_d <= snooze;
            if (state == IDLE && state_next == BEEP_ON) begin
                snooze_cnt <= '0;
            end else if (state != SNOOZE && state_next == SNOOZE) begin
                snooze_cnt <= snooze_cnt + 1'b1;
            end
        end
    end
`else
    // Snooze input and its settings are deliberately dropped in this build.
    logic unused_snooze;
    assign unused_snooze = snooze ^ (SNOOZE_TICKS == 0) ^ (MAX_SNOOZE == 0);
    assign snooze_take   = 1'b0;
    assign snoozed       = 1'b0;
`endif

    assign aud_en  = (state == BEEP_ON);
    assign ringing = ring_state;

    // Last tick index of the current state; the state ends on that tick.
    always_comb begin
        dur_last = '0;
        case (state)
            BEEP_ON:  dur_last = DUR_W'(ON_TICKS - 1);
            BEEP_OFF: dur_last = DUR_W'(OFF_TICKS - 1);
            GAP:      dur_last = DUR_W'(GAP_TICKS - 1);
`ifdef ALARM_SNOOZE_EN
            SNOOZE:   dur_last = DUR_W'(SNOOZE_TICKS - 1);
`endif
            default:  dur_last = '0;
        endcase
    end

    assign dur_done = tick && (dur_cnt == dur_last);

    // Priority in ringing states: stop > timeout > snooze > cadence.
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (alarm_hit) state_next = BEEP_ON;
                end
                BEEP_ON, BEEP_OFF, GAP: begin
                    if (ring_expire) begin
                        state_next = IDLE;
                    end else if (snooze_take) begin
                        state_next = SNOOZE;
                    end else if (dur_done) begin
                        case (state)
                            BEEP_ON:  state_next = BEEP_OFF;
                            BEEP_OFF: state_next = (burst_cnt < BURST_W'(BURSTS)) ? BEEP_ON : GAP;
                            default:  state_next = BEEP_ON;
                        endcase
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (dur_done) state_next = BEEP_ON;
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Burst count advances as each beep ends; ring timer and burst count
    // restart whenever ringing (re)starts from IDLE or SNOOZE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dur_cnt   <= '0;
            burst_cnt <= '0;
            ring_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= ring_expire && !stop;

            if (state_change) begin
                dur_cnt <= '0;
            end else if (tick && state != IDLE && dur_cnt != DUR_W'(DUR_MAX)) begin
                dur_cnt <= dur_cnt + 1'b1;
            end

            if (state_next == GAP ||
                (state_next == BEEP_ON && (state == IDLE || state == SNOOZE))) begin
                burst_cnt <= '0;
            end else if (state == BEEP_ON && state_next == BEEP_OFF &&
                         burst_cnt != BURST_W'(BURSTS)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            if (state_next == BEEP_ON && (state == IDLE || state == SNOOZE)) begin
                ring_cnt <= '0;
            end else if (ring_state && tick && ring_cnt != RING_W'(RING_TICKS)) begin
                ring_cnt <= ring_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alarm_beep_ctrl.sv
// tb_alarm_beep_ctrl
//   Self-checking bench for alarm_beep_ctrl with small timing parameters.
//   Expected output vectors {aud_en, ringing, snoozed, timeout} are pushed
//   to a queue as each cycle's stimulus is driven and popped once the DUT
//   has responded to that clock edge.
module tb_alarm_beep_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int ON_TICKS     = 2;
    localparam int OFF_TICKS    = 1;
    localparam int BURSTS       = 2;
    localparam int GAP_TICKS    = 3;
    localparam int RING_TICKS   = 40;
    localparam int SNOOZE_TICKS = 5;
    localparam int MAX_SNOOZE   = 1;

    localparam int ON_CYC    = ON_TICKS * TICK_DIV;
    localparam int BEEP_CYC  = (ON_TICKS + OFF_TICKS) * TICK_DIV;
    localparam int BURST_CYC = BURSTS * BEEP_CYC;
    localparam int GROUP_CYC = BURST_CYC + GAP_TICKS * TICK_DIV;
    localparam int RING_CYC  = RING_TICKS * TICK_DIV;
    localparam int SNZ_CYC   = SNOOZE_TICKS * TICK_DIV;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic alarm_hit = 1'b0;
    logic stop = 1'b0;
    logic snooze = 1'b0;
    logic aud_en, ringing, snoozed, timeout;
    logic [3:0] obs;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    assign obs = {aud_en, ringing, snoozed, timeout};

    always #5 clk = ~clk;

    alarm_beep_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .ON_TICKS    (ON_TICKS),
        .OFF_TICKS   (OFF_TICKS),
        .BURSTS      (BURSTS),
        .GAP_TICKS   (GAP_TICKS),
        .RING_TICKS  (RING_TICKS),
        .SNOOZE_TICKS(SNOOZE_TICKS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .alarm_hit(alarm_hit),
        .stop     (stop),
        .snooze   (snooze),
        .aud_en   (aud_en),
        .ringing  (ringing),
        .snoozed  (snoozed),
        .timeout  (timeout)
    );

    // Output vector k cycles into ringing (k=1 is the first BEEP_ON cycle).
    function automatic logic [3:0] cadence(input int k);
        int p;
        logic on;
        p  = (k - 1) % GROUP_CYC;
        on = (p < BURST_CYC) && ((p % BEEP_CYC) < ON_CYC);
        return {on, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic silence(input string name);
        stop      = 1'b1;
        alarm_hit = 1'b0;
        snooze    = 1'b0;
        step();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL %s_stop got=%b exp=%b", name, obs, 4'b0000);
        end
        stop = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_immediate got=%b exp=%b", obs, 4'b0000);
        end
        alarm_hit = 1'b1;
        step();
        step();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_held got=%b exp=%b", obs, 4'b0000);
        end
        alarm_hit = 1'b0;
        #3 rstn = 1'b1;
        step();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_idle got=%b exp=%b", obs, 4'b0000);
        end
    endtask

    task automatic test_cadence();
        logic [3:0] e;
        for (int c = 1; c <= 80; c++) begin
            alarm_hit = (c == 1);
            exp_q.push_back(cadence(c));
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL cadence c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        silence("cadence");
    endtask

    task automatic test_stop();
        logic [3:0] e;
        for (int c = 1; c <= 30; c++) begin
            alarm_hit = (c == 1) || (c == 7) || (c == 13);
            stop      = (c == 6) || (c == 7);
            if (c <= 5)       exp_q.push_back(cadence(c));
            else if (c <= 12) exp_q.push_back(4'b0000);
            else              exp_q.push_back(cadence(c - 12));
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL stop c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        silence("stop");
    endtask

    task automatic test_timeout();
        logic [3:0] e;
        int pulses;
        pulses = 0;
        for (int c = 1; c <= RING_CYC + 10; c++) begin
            alarm_hit = (c == 1);
            if (c <= RING_CYC)          exp_q.push_back(cadence(c));
            else if (c == RING_CYC + 1) exp_q.push_back(4'b0001);
            else                        exp_q.push_back(4'b0000);
            step();
            if (timeout === 1'b1) pulses++;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL timeout c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulses got=%0d exp=1", pulses);
        end
        silence("timeout");
    endtask

    task automatic test_snooze();
        logic [3:0] e;
        for (int c = 1; c <= 75; c++) begin
            alarm_hit = (c == 1);
            snooze    = (c == 28) || (c >= 51 && c <= 53);
`ifdef ALARM_SNOOZE_EN
            if (c <= 27)                exp_q.push_back(cadence(c));
            else if (c <= 27 + SNZ_CYC) exp_q.push_back(4'b0010);
            else                        exp_q.push_back(cadence(c - 27 - SNZ_CYC));
`else
            exp_q.push_back(cadence(c));
`endif
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL snooze c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        silence("snooze");
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        for (int c = 1; c <= 3; c++) begin
            alarm_hit = (c == 1);
            exp_q.push_back(cadence(c));
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL async_pre c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        alarm_hit = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_reset got=%b exp=%b", obs, 4'b0000);
        end
        step();
        #3 rstn = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            alarm_hit = (c == 5);
            if (c < 5) exp_q.push_back(4'b0000);
            else       exp_q.push_back(cadence(c - 4));
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL async_post c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        silence("async");
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        for (int c = 1; c <= 44; c++) begin
            alarm_hit = (c == 1) || (c == 5) || (c == 10) || (c >= 14 && c <= 30);
            exp_q.push_back(cadence(c));
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        stop = 1'b1;
        alarm_hit = 1'b0;
        step();
        stop = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            alarm_hit = (c == 1);
            exp_q.push_back(cadence(c));
            step();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL restart c=%0d got=%b exp=%b", c, obs, e);
            end
        end
        silence("back_to_back");
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_stop();
        test_timeout();
        test_snooze();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
